u712_cycle_sequencer: RTL
=========================

Name: u712_cycle_sequencer

Overview:
Sequences every MC68040/MC68060 bus cycle claimed by U712, from transfer start to final acknowledge. It steers the register and RAM datapaths by driving REG_TA, RAM_TA and BURST_CYCLE into the transfer-acknowledge block, and it counts line-burst beats. It also terminates unclaimed or hung cycles with a bus-error timeout. It sits between the CPU bus decode and the transfer-ack output stage.

Parameters:
TIMEOUT_CYCLES, 255, CLK40 cycles without a beat acknowledge before the cycle is ended with transfer error; counter width is clog2(TIMEOUT_CYCLES+1).
LINE_BEATS, 4, beats in a line (burst) transfer.

Ports:
CLK40  input  1  system clock, 40 MHz, rising edge.
nRESET  input  1  asynchronous active-low reset.
nTS  input  1  CPU transfer start, active low, one-cycle strobe.
SIZ  input  2  CPU transfer size; 2'b11 = line burst.
REG_REQ  input  1  address decode: register space hit, valid from the DECODE cycle onward.
RAM_REQ  input  1  address decode: RAM space hit.
REG_RDY  input  1  register datapath data ready, one-cycle strobe.
RAM_RDY  input  1  RAM datapath beat ready, one-cycle strobe.
DMA_PREEMPT  input  1  DMA needs the RAM; burst must be abandoned.
REG_TA  output  1  registered register-cycle acknowledge pulse.
RAM_TA  output  1  registered RAM beat acknowledge pulse.
BURST_CYCLE  output  1  current RAM cycle continues as an uninterrupted burst.
nTEA  output  1  transfer error acknowledge, active low.
CYCLE_ACTIVE  output  1  high from DECODE through ACK.
BEAT  output  2  index of the next RAM beat to acknowledge.

Behaviour:
- Reset is nRESET, asynchronous, active-low; the clock is CLK40. In reset: state IDLE, REG_TA=0, RAM_TA=0, BURST_CYCLE=0, nTEA=1, CYCLE_ACTIVE=0, BEAT=0, timeout counter=0.
- All outputs are registered.
- Reset asserted mid-cycle forces the reset values immediately. There is no completion of the in-flight cycle.
- States: IDLE, DECODE, REG_WAIT, RAM_WAIT, ACK, RECOVER.
- IDLE:
  - nTS=0 sampled at an edge latches burst=(SIZ==2'b11) and moves to DECODE.
  - The timeout counter clears on entry to DECODE.
- DECODE:
  - REG_REQ moves to REG_WAIT.
  - Otherwise RAM_REQ moves to RAM_WAIT and sets BURST_CYCLE=burst.
  - REG_REQ and RAM_REQ both high: REG wins.
  - Neither high: stay in DECODE and count toward timeout.
- REG_WAIT: REG_RDY moves to ACK, with REG_TA=1 for exactly one cycle. Register cycles are always a single beat, even if burst was latched.
- RAM_WAIT:
  - Each RAM_RDY gives RAM_TA=1 for one cycle, increments BEAT, and clears the timeout counter.
  - Non-burst: the first beat moves to ACK.
  - Burst: the beat with BEAT==LINE_BEATS-1 moves to ACK. BEAT wraps to 0.
- DMA_PREEMPT in RAM_WAIT while BEAT==0:
  - BURST_CYCLE clears on the next edge.
  - The next RAM_RDY beat ends the cycle (CPU sees TBI and reruns).
  - DMA_PREEMPT when BEAT!=0 is ignored; the burst completes.
  - DMA_PREEMPT coincident with the first RAM_RDY: BURST_CYCLE is 0 in the same cycle RAM_TA=1, and the cycle ends after that beat.
- ACK: one cycle with the TA pulse high, then RECOVER. CYCLE_ACTIVE drops and BURST_CYCLE clears on entry to RECOVER.
- RECOVER:
  - Outputs are idle.
  - nTS=0 here is accepted: latch SIZ and go to DECODE, so back-to-back cycles are supported.
  - Otherwise go to IDLE.
- REG_RDY or RAM_RDY outside its matching wait state is ignored.
- Timeout (DECODE/REG_WAIT/RAM_WAIT):
  - The counter reaching TIMEOUT_CYCLES drives nTEA=0 for one cycle, with no TA.
  - The state moves to RECOVER, and BEAT and BURST_CYCLE clear.
  - A RDY strobe in the same cycle as the terminal count wins, and the counter restarts.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: the timeout counter and nTEA generation are present as described above.
- Undefined: no counter is built and nTEA is tied to 1. Wait states hold indefinitely until the matching RDY strobe arrives; an undecoded cycle stays in DECODE until reset.

Test Plan:
- Register read: nTS with SIZ=2'b00 and REG_REQ=1, REG_RDY 3 cycles after DECODE -> REG_TA high exactly 1 cycle; RAM_TA=0, BURST_CYCLE=0, nTEA=1; back to IDLE 2 cycles later.
- RAM line burst: SIZ=2'b11, RAM_REQ=1, four RAM_RDY strobes 2 cycles apart -> four 1-cycle RAM_TA pulses, BEAT 0->1->2->3->0, BURST_CYCLE=1 throughout until RECOVER.
- DMA preempt: burst RAM cycle, DMA_PREEMPT before the first RAM_RDY -> BURST_CYCLE=0 at the first RAM_TA, single beat only, cycle ends; DMA_PREEMPT after beat 1 -> all four beats acknowledged.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): nTS with REG_REQ=RAM_REQ=0 -> nTEA low exactly 1 cycle at count 16, no TA, then IDLE; without the macro, nTEA stays 1 and the state holds DECODE.
- Back-to-back: nTS asserted in the RECOVER cycle after a RAM single beat -> the next cycle enters DECODE with no IDLE cycle, and the new SIZ is latched.
- Reset mid-burst: nRESET low after beat 2 -> all outputs at reset values asynchronously; after release, a new nTS starts cleanly with BEAT=0.

Source files
------------

// File: rtl/u712_cycle_sequencer.sv
// u712_cycle_sequencer: sequences each claimed 68040/68060 bus cycle
// from transfer start to final acknowledge, counting line-burst beats.
//
// Ports:
//   CLK40        in   system clock, rising edge
//   nRESET       in   asynchronous active-low reset
//   nTS          in   CPU transfer start strobe, active low
//   SIZ[1:0]     in   CPU transfer size, 2'b11 = line burst
//   REG_REQ      in   decode hit in register space
//   RAM_REQ      in   decode hit in RAM space
//   REG_RDY      in   register datapath ready strobe
//   RAM_RDY      in   RAM datapath beat-ready strobe
//   DMA_PREEMPT  in   DMA wants the RAM, abandon a burst not yet started
//   REG_TA       out  register-cycle acknowledge pulse
//   RAM_TA       out  RAM beat acknowledge pulse
//   BURST_CYCLE  out  RAM cycle proceeds as an uninterrupted burst
//   nTEA         out  transfer error acknowledge, active low
//   CYCLE_ACTIVE out  high from DECODE through ACK
//   BEAT[1:0]    out  index of the next RAM beat to acknowledge
//
// Build option BUS_TIMEOUT_EN: when defined, a watchdog ends cycles that
// go TIMEOUT_CYCLES clocks without a beat acknowledge by pulsing nTEA.
// When undefined, no counter exists, nTEA is tied high and waits are
// unbounded.

module u712_cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LINE_BEATS     = 4
) (
    input  logic       CLK40,
    input  logic       nRESET,
    input  logic       nTS,
    input  logic [1:0] SIZ,
    input  logic       REG_REQ,
    input  logic       RAM_REQ,
    input  logic       REG_RDY,
    input  logic       RAM_RDY,
    input  logic       DMA_PREEMPT,
    output logic       REG_TA,
    output logic       RAM_TA,
    output logic       BURST_CYCLE,
    output logic       nTEA,
    output logic       CYCLE_ACTIVE,
    output logic [1:0] BEAT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_REG_WAIT,
        S_RAM_WAIT,
        S_ACK,
        S_RECOVER
    } state_t;

    localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

    state_t     state_q, state_d;
    logic       line_q, line_d;
    logic       reg_ta_q, reg_ta_d;
    logic       ram_ta_q, ram_ta_d;
    logic       burst_q, burst_d;
    logic       ntea_q, ntea_d;
    logic       active_q, active_d;
    logic [1:0] beat_q, beat_d;

    // Burst still in force for this beat: a preempt seen before the first
    // beat is applied in the same cycle so a coincident RAM_RDY ends it.
    logic       preempt;
    logic       burst_eff;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;
    logic          rdy_taken;
`endif

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        reg_ta_d  = 1'b0;
        ram_ta_d  = 1'b0;
        burst_d   = burst_q;
        ntea_d    = 1'b1;
        beat_d    = beat_q;
        preempt   = 1'b0;
        burst_eff = burst_q;

        unique case (state_q)
            S_IDLE: begin
                if (!nTS) begin
                    state_d = S_DECODE;
                    line_d  = (SIZ == 2'b11);
                end
            end

            S_DECODE: begin
                if (REG_REQ) begin
                    state_d = S_REG_WAIT;
                end else if (RAM_REQ) begin
                    state_d = S_RAM_WAIT;
                    burst_d = line_q;
                end
            end

            S_REG_WAIT: begin
                if (REG_RDY) begin
                    state_d  = S_ACK;
                    reg_ta_d = 1'b1;
                end
            end

            S_RAM_WAIT: begin
                preempt   = DMA_PREEMPT && (beat_q == 2'd0);
                burst_eff = burst_q && !preempt;
                burst_d   = burst_eff;
                if (RAM_RDY) begin
                    ram_ta_d = 1'b1;
                    // BEAT names the next beat; it returns to 0 as the
                    // cycle finishes so the next cycle starts at beat 0.
                    if (!burst_eff || (beat_q == LAST_BEAT)) begin
                        state_d = S_ACK;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                    end
                end
            end

            S_ACK: begin
                state_d = S_RECOVER;
                burst_d = 1'b0;
            end

            S_RECOVER: begin
                if (!nTS) begin
                    state_d = S_DECODE;
                    line_d  = (SIZ == 2'b11);
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
        waiting   = (state_q == S_DECODE) ||
                    (state_q == S_REG_WAIT) ||
                    (state_q == S_RAM_WAIT);
        rdy_taken = ((state_q == S_REG_WAIT) && REG_RDY) ||
                    ((state_q == S_RAM_WAIT) && RAM_RDY);

        if (waiting) begin
            if (rdy_taken) begin
                // An acknowledge on the terminal count still wins.
                cnt_d = '0;
            end else if (cnt_q == TERM) begin
                state_d  = S_RECOVER;
                ntea_d   = 1'b0;
                reg_ta_d = 1'b0;
                ram_ta_d = 1'b0;
                burst_d  = 1'b0;
                beat_d   = 2'd0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if ((state_d == S_DECODE) && (state_q != S_DECODE)) begin
            cnt_d = '0;
        end
`endif

        active_d = (state_d == S_DECODE)   ||
                   (state_d == S_REG_WAIT) ||
                   (state_d == S_RAM_WAIT) ||
                   (state_d == S_ACK);
    end

    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            line_q   <= 1'b0;
            reg_ta_q <= 1'b0;
            ram_ta_q <= 1'b0;
            burst_q  <= 1'b0;
            ntea_q   <= 1'b1;
            active_q <= 1'b0;
            beat_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            reg_ta_q <= reg_ta_d;
            ram_ta_q <= ram_ta_d;
            burst_q  <= burst_d;
            ntea_q   <= ntea_d;
            active_q <= active_d;
            beat_q   <= beat_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign REG_TA       = reg_ta_q;
    assign RAM_TA       = ram_ta_q;
    assign BURST_CYCLE  = burst_q;
    assign nTEA         = ntea_q;
    assign CYCLE_ACTIVE = active_q;
    assign BEAT         = beat_q;

endmodule
